// File: rtl/tap_state_controller_if.sv
`default_nettype none
// ============================================================================
//  tap_state_controller_if
//  JTAG TAP pin-side and register-column signal bundle.
//  Rev 1.0
// ============================================================================
interface tap_state_controller_if;
  logic       tms;
  logic       ir_tdo;
  logic       dr_tdo;
  logic [3:0] state;
  logic       test_logic_reset;
  logic       run_test_idle;
  logic       select_ir;
  logic       capture_ir;
  logic       shift_ir;
  logic       capture_dr;
  logic       shift_dr;
  logic       update_ir;
  logic       update_dr;
  logic       tdo;
  logic       tdo_en;

  modport master (
    output tms, ir_tdo, dr_tdo,
    input  state, test_logic_reset, run_test_idle, select_ir,
           capture_ir, shift_ir, capture_dr, shift_dr,
           update_ir, update_dr, tdo, tdo_en
  );

  modport slave (
    input  tms, ir_tdo, dr_tdo,
    output state, test_logic_reset, run_test_idle, select_ir,
           capture_ir, shift_ir, capture_dr, shift_dr,
           update_ir, update_dr, tdo, tdo_en
  );
endinterface
`default_nettype wire

// File: rtl/tap_state_controller.sv
`default_nettype none
// ============================================================================
//  tap_state_controller
//  IEEE 1149.1 TAP FSM with falling-edge update strobes and TDO retiming.
//  Rev 1.0
// ============================================================================
module tap_state_controller (
  input wire tck,
  input wire tl_reset,
  tap_state_controller_if.slave jtag
);

  typedef enum logic [3:0] {
    TLR     = 4'hF,
    RTI     = 4'hC,
    SELDR   = 4'h7,
    CAPDR   = 4'h6,
    SHDR    = 4'h2,
    EX1DR   = 4'h1,
    PAUSEDR = 4'h3,
    EX2DR   = 4'h0,
    UPDDR   = 4'h5,
    SELIR   = 4'h4,
    CAPIR   = 4'hE,
    SHIR    = 4'hA,
    EX1IR   = 4'h9,
    PAUSEIR = 4'hB,
    EX2IR   = 4'h8,
    UPDIR   = 4'hD
  } tap_state_e;

  tap_state_e state_q, state_d;
  logic       update_ir_q, update_dr_q, tlr_q, tdo_q, tdo_en_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:     state_d = jtag.tms ? TLR     : RTI;
      RTI:     state_d = jtag.tms ? SELDR   : RTI;
      SELDR:   state_d = jtag.tms ? SELIR   : CAPDR;
      CAPDR:   state_d = jtag.tms ? EX1DR   : SHDR;
      SHDR:    state_d = jtag.tms ? EX1DR   : SHDR;
      EX1DR:   state_d = jtag.tms ? UPDDR   : PAUSEDR;
      PAUSEDR: state_d = jtag.tms ? EX2DR   : PAUSEDR;
      EX2DR:   state_d = jtag.tms ? UPDDR   : SHDR;
      UPDDR:   state_d = jtag.tms ? SELDR   : RTI;
      SELIR:   state_d = jtag.tms ? TLR     : CAPIR;
      CAPIR:   state_d = jtag.tms ? EX1IR   : SHIR;
      SHIR:    state_d = jtag.tms ? EX1IR   : SHIR;
      EX1IR:   state_d = jtag.tms ? UPDIR   : PAUSEIR;
      PAUSEIR: state_d = jtag.tms ? EX2IR   : PAUSEIR;
      EX2IR:   state_d = jtag.tms ? UPDIR   : SHIR;
      UPDIR:   state_d = jtag.tms ? SELDR   : RTI;
      default: state_d = TLR;
    endcase
  end

  always_ff @(posedge tck or posedge tl_reset) begin
    if (tl_reset) state_q <= TLR;
    else          state_q <= state_d;
  end

  // Strobes are used as clocks downstream, so they come straight from flops.
  always_ff @(negedge tck or posedge tl_reset) begin
    if (tl_reset) begin
      update_ir_q <= 1'b0;
      update_dr_q <= 1'b0;
      tlr_q       <= 1'b1;
      tdo_q       <= 1'b0;
      tdo_en_q    <= 1'b0;
    end else begin
      update_ir_q <= (state_q == UPDIR);
      update_dr_q <= (state_q == UPDDR);
      tlr_q       <= (state_q == TLR);
      tdo_en_q    <= (state_q == SHIR) || (state_q == SHDR);
      if (state_q == SHIR)      tdo_q <= jtag.ir_tdo;
      else if (state_q == SHDR) tdo_q <= jtag.dr_tdo;
      else                      tdo_q <= 1'b0;
    end
  end

  assign jtag.state            = state_q;
  assign jtag.run_test_idle    = (state_q == RTI);
  assign jtag.select_ir        = (state_q == SELIR) || (state_q == CAPIR) || (state_q == SHIR) ||
                                 (state_q == EX1IR) || (state_q == PAUSEIR) || (state_q == EX2IR) ||
                                 (state_q == UPDIR);
  assign jtag.capture_ir       = (state_q == CAPIR);
  assign jtag.shift_ir         = (state_q == SHIR);
  assign jtag.capture_dr       = (state_q == CAPDR);
  assign jtag.shift_dr         = (state_q == SHDR);
  assign jtag.update_ir        = update_ir_q;
  assign jtag.update_dr        = update_dr_q;
  assign jtag.test_logic_reset = tlr_q;
  assign jtag.tdo              = tdo_q;
  assign jtag.tdo_en           = tdo_en_q;

endmodule
`default_nettype wire

// File: tb/tb_tap_state_controller.sv
`default_nettype none
// ============================================================================
//  tb_tap_state_controller
//  Directed scans plus random TMS walks checked against a table-driven model.
//  Rev 1.0
// ============================================================================
module tb_tap_state_controller;

  localparam logic [3:0] S_TLR = 4'hF, S_RTI = 4'hC, S_SELDR = 4'h7, S_CAPDR = 4'h6;
  localparam logic [3:0] S_SHDR = 4'h2, S_EX1DR = 4'h1, S_PAUDR = 4'h3, S_EX2DR = 4'h0;
  localparam logic [3:0] S_UPDDR = 4'h5, S_SELIR = 4'h4, S_CAPIR = 4'hE, S_SHIR = 4'hA;
  localparam logic [3:0] S_EX1IR = 4'h9, S_PAUIR = 4'hB, S_EX2IR = 4'h8, S_UPDIR = 4'hD;

  logic tck = 1'b0;
  logic tl_reset = 1'b0;

  tap_state_controller_if bus ();

  tap_state_controller dut (
    .tck      (tck),
    .tl_reset (tl_reset),
    .jtag     (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: successor tables filled from the TAP transition rules.
  logic [3:0] nxt0 [16];
  logic [3:0] nxt1 [16];
  logic [3:0] m_state;
  logic       m_upd_ir, m_upd_dr, m_tlr, m_tdo, m_tdo_en;
  int         ones;
  int         sh_ir_cnt, upd_ir_cnt, upd_dr_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic build_tables();
    logic [3:0] cap [2], sh [2], ex1 [2], pau [2], ex2 [2], upd [2];
    cap = '{S_CAPDR, S_CAPIR}; sh  = '{S_SHDR,  S_SHIR};
    ex1 = '{S_EX1DR, S_EX1IR}; pau = '{S_PAUDR, S_PAUIR};
    ex2 = '{S_EX2DR, S_EX2IR}; upd = '{S_UPDDR, S_UPDIR};
    nxt0[S_TLR]   = S_RTI;   nxt1[S_TLR]   = S_TLR;
    nxt0[S_RTI]   = S_RTI;   nxt1[S_RTI]   = S_SELDR;
    nxt0[S_SELDR] = S_CAPDR; nxt1[S_SELDR] = S_SELIR;
    nxt0[S_SELIR] = S_CAPIR; nxt1[S_SELIR] = S_TLR;
    for (int c = 0; c < 2; c++) begin
      nxt0[cap[c]] = sh[c];  nxt1[cap[c]] = ex1[c];
      nxt0[sh[c]]  = sh[c];  nxt1[sh[c]]  = ex1[c];
      nxt0[ex1[c]] = pau[c]; nxt1[ex1[c]] = upd[c];
      nxt0[pau[c]] = pau[c]; nxt1[pau[c]] = ex2[c];
      nxt0[ex2[c]] = sh[c];  nxt1[ex2[c]] = upd[c];
      nxt0[upd[c]] = S_RTI;  nxt1[upd[c]] = S_SELDR;
    end
  endtask

  function automatic logic in_ir_column(input logic [3:0] s);
    return s inside {S_SELIR, S_CAPIR, S_SHIR, S_EX1IR, S_PAUIR, S_EX2IR, S_UPDIR};
  endfunction

  // One full tck period; tck is low on entry and exit.
  task automatic step(input logic t, input logic ir_v, input logic dr_v);
    bus.tms = t; bus.ir_tdo = ir_v; bus.dr_tdo = dr_v;
    #2 tck = 1'b1;
    m_state = t ? nxt1[m_state] : nxt0[m_state];
    ones = t ? ones + 1 : 0;
    #1;
    check("state",      bus.state,         m_state);
    check("run_idle",   bus.run_test_idle, m_state == S_RTI);
    check("select_ir",  bus.select_ir,     in_ir_column(m_state));
    check("capture_ir", bus.capture_ir,    m_state == S_CAPIR);
    check("shift_ir",   bus.shift_ir,      m_state == S_SHIR);
    check("capture_dr", bus.capture_dr,    m_state == S_CAPDR);
    check("shift_dr",   bus.shift_dr,      m_state == S_SHDR);
    if (ones >= 5) check("five_tms_tlr", bus.state, S_TLR);
    if (bus.shift_ir === 1'b1) sh_ir_cnt++;
    #2 tck = 1'b0;
    m_upd_ir = (m_state == S_UPDIR);
    m_upd_dr = (m_state == S_UPDDR);
    m_tlr    = (m_state == S_TLR);
    m_tdo_en = (m_state == S_SHIR) || (m_state == S_SHDR);
    m_tdo    = (m_state == S_SHIR) ? ir_v : (m_state == S_SHDR) ? dr_v : 1'b0;
    #1;
    check("tlr_out",   bus.test_logic_reset, m_tlr);
    check("update_ir", bus.update_ir,        m_upd_ir);
    check("update_dr", bus.update_dr,        m_upd_dr);
    check("tdo",       bus.tdo,              m_tdo);
    check("tdo_en",    bus.tdo_en,           m_tdo_en);
    if (bus.update_ir === 1'b1) upd_ir_cnt++;
    if (bus.update_dr === 1'b1) upd_dr_cnt++;
    #4;
  endtask

  // Asynchronous reset with tck held low; outputs must settle without an edge.
  task automatic pulse_reset();
    tl_reset = 1'b1;
    #1;
    m_state = S_TLR; m_tlr = 1'b1; m_upd_ir = 1'b0; m_upd_dr = 1'b0;
    m_tdo = 1'b0; m_tdo_en = 1'b0; ones = 0;
    check("rst_state",   bus.state,            S_TLR);
    check("rst_tlr",     bus.test_logic_reset, 1'b1);
    check("rst_upd_ir",  bus.update_ir,        1'b0);
    check("rst_upd_dr",  bus.update_dr,        1'b0);
    check("rst_tdo",     bus.tdo,              1'b0);
    check("rst_tdo_en",  bus.tdo_en,           1'b0);
    check("rst_rti",     bus.run_test_idle,    1'b0);
    check("rst_sel_ir",  bus.select_ir,        1'b0);
    check("rst_shifts",  {bus.capture_ir, bus.shift_ir, bus.capture_dr, bus.shift_dr}, 4'b0);
    #2 tl_reset = 1'b0;
    #2;
  endtask

  task automatic run_seq(input logic [15:0] bits, input int n, input logic ir_v, input logic dr_v);
    for (int i = n - 1; i >= 0; i--) step(bits[i], ir_v, dr_v);
  endtask

  logic [3:0] dr_seq [10];
  logic       dr_tms [10];

  initial begin
    bus.tms = 1'b1; bus.ir_tdo = 1'b0; bus.dr_tdo = 1'b0;
    build_tables();
    ones = 0; sh_ir_cnt = 0; upd_ir_cnt = 0; upd_dr_cnt = 0;
    #5;
    pulse_reset();

    // TLR recovery from ShDR with five TMS=1 edges
    run_seq(16'b0100, 4, 1'b0, 1'b1);
    check("reach_shdr", bus.state, S_SHDR);
    run_seq(16'b11111, 5, 1'b0, 1'b1);
    check("recover_state", bus.state, S_TLR);
    check("recover_tlr",   bus.test_logic_reset, 1'b1);

    // IR scan
    step(1'b0, 1'b0, 1'b0);
    sh_ir_cnt = 0; upd_ir_cnt = 0;
    run_seq(16'b1100, 4, 1'b1, 1'b0);
    check("ir_in_shift", bus.state, S_SHIR);
    run_seq(16'b000110, 6, 1'b1, 1'b0);
    check("ir_shift_cnt",  sh_ir_cnt,  4);
    check("ir_update_cnt", upd_ir_cnt, 1);
    check("ir_final",      bus.state,  S_RTI);

    // DR scan through pause, never reaching Update-DR
    dr_tms = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    dr_seq = '{S_SELDR, S_CAPDR, S_SHDR, S_EX1DR, S_PAUDR, S_PAUDR, S_EX2DR, S_SHDR, S_EX1DR, S_PAUDR};
    upd_dr_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(dr_tms[i], 1'b0, 1'b1);
      check("dr_seq", bus.state, dr_seq[i]);
    end
    check("dr_no_update", upd_dr_cnt, 0);

    // TDO mux: Pause-DR -> Ex2 -> Upd -> RTI, then into Shift-IR
    run_seq(16'b110, 3, 1'b1, 1'b0);
    run_seq(16'b1100, 4, 1'b1, 1'b0);
    check("tdo_shir",    bus.tdo,    1'b1);
    check("tdo_en_shir", bus.tdo_en, 1'b1);
    run_seq(16'b11100, 5, 1'b1, 1'b0);
    check("tdo_shdr",    bus.tdo,    1'b0);
    check("tdo_en_shdr", bus.tdo_en, 1'b1);
    run_seq(16'b110, 3, 1'b1, 1'b0);
    check("tdo_en_rti",  bus.tdo_en, 1'b0);

    // Reset while Update-DR strobe is high
    run_seq(16'b1011, 4, 1'b0, 1'b0);
    check("upd_dr_high", bus.update_dr, 1'b1);
    pulse_reset();

    // Random walk with occasional asynchronous resets
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 49) == 0) pulse_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
